// File: rtl/stb_cdc_multi.sv
// stb_cdc_multi: multi-channel loss-free strobe crossing, stb_i_clk -> stb_o_clk.
// Each channel counts incoming strobes and forwards them one at a time over a
// 4-phase req/ack handshake. Each completed handshake produces one stb_o pulse.
// Ports:
//   stb_i_clk  source clock
//   lock_rst   async active-high reset (also drives a synchronised destination reset)
//   stb_o_clk  destination clock
//   stb_i      per-channel input strobe (stb_i_clk)
//   ovf_clr_i  per-channel sticky-overflow clear (stb_i_clk)
//   busy_o     channel has pending strobes or a handshake in flight (stb_i_clk)
//   ovf_o      sticky: a strobe was dropped because the counter was full (stb_i_clk)
//   stb_o      per-channel single-cycle output strobe (stb_o_clk)
module stb_cdc_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic                stb_i_clk,
  input  logic                lock_rst,
  input  logic                stb_o_clk,
  input  logic [CHANNELS-1:0] stb_i,
  input  logic [CHANNELS-1:0] ovf_clr_i,
  output logic [CHANNELS-1:0] busy_o,
  output logic [CHANNELS-1:0] ovf_o,
  output logic [CHANNELS-1:0] stb_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Destination reset: asserts with lock_rst, releases after SYNC_STAGES stb_o_clk edges.
  logic [SYNC_STAGES-1:0] dst_rst_q;
  logic                   dst_rst;

  always_ff @(posedge stb_o_clk or posedge lock_rst) begin
    if (lock_rst) begin
      dst_rst_q <= '1;
    end else begin
      dst_rst_q <= {dst_rst_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign dst_rst = dst_rst_q[SYNC_STAGES-1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   req_q, req_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q, ovf_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   req_s_d_q;
    logic                   stb_q;
    logic                   ack_s, req_s;
    logic                   inc, dec, drop;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];
    assign req_s = req_sync_q[SYNC_STAGES-1];

    // Source-domain state register.
    always_ff @(posedge stb_i_clk or posedge lock_rst) begin
      if (lock_rst) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        req_q      <= 1'b0;
        busy_q     <= 1'b0;
        ovf_q      <= 1'b0;
        ack_sync_q <= '0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        req_q      <= req_d;
        busy_q     <= busy_d;
        ovf_q      <= ovf_d;
        ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], req_s};
      end
    end

    // Handshake FSM, pending counter and overflow flag.
    always_comb begin
      state_d = state_q;
      req_d   = req_q;
      dec     = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cnt_q != '0) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            dec     = 1'b1;
            req_d   = 1'b0;
            state_d = ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!ack_s) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      endcase

      // A full counter still accepts a strobe when a slot frees on the same edge.
      inc  = stb_i[g] & ((cnt_q != CNT_MAX) | dec);
      drop = stb_i[g] & ~inc;

      cnt_d = cnt_q;
      if (inc && !dec) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_d = cnt_q - CNT_ONE;
      end

      ovf_d  = drop | (ovf_q & ~ovf_clr_i[g]);
      // Built from next-state values so the registered flag tracks the current state exactly.
      busy_d = (cnt_d != '0) | (state_d != ST_IDLE);
    end

    // Destination-domain request synchroniser and edge detector.
    always_ff @(posedge stb_o_clk or posedge dst_rst) begin
      if (dst_rst) begin
        req_sync_q <= '0;
        req_s_d_q  <= 1'b0;
        stb_q      <= 1'b0;
      end else begin
        req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
        req_s_d_q  <= req_s;
        stb_q      <= req_s & ~req_s_d_q;
      end
    end

    assign busy_o[g] = busy_q;
    assign ovf_o[g]  = ovf_q;
    assign stb_o[g]  = stb_q;
  end

endmodule

// File: tb/tb_stb_cdc_multi.sv
// tb_stb_cdc_multi: scoreboard bench for stb_cdc_multi.
// Stimulus pushes one expected pulse per accepted strobe; a monitor on the
// destination clock pops an entry for every stb_o pulse it observes.
`timescale 1ns/1ps
module tb_stb_cdc_multi;

  localparam int unsigned CH = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned CW = 4;

  logic          stb_i_clk;
  logic          stb_o_clk;
  logic          lock_rst;
  logic [CH-1:0] stb_i;
  logic [CH-1:0] ovf_clr_i;
  logic [CH-1:0] busy_o;
  logic [CH-1:0] ovf_o;
  logic [CH-1:0] stb_o;

  realtime src_half;
  realtime dst_half;
  logic    dst_run;

  typedef struct {
    int      ch;
    realtime deadline;
  } exp_t;

  exp_t          exp_q[$];
  int            n_vec;
  int            n_miss;
  int            pulse_cnt[CH];
  logic [CH-1:0] stb_prev;

  stb_cdc_multi #(
    .CHANNELS   (CH),
    .SYNC_STAGES(SS),
    .CNT_WIDTH  (CW)
  ) dut (
    .stb_i_clk(stb_i_clk),
    .lock_rst (lock_rst),
    .stb_o_clk(stb_o_clk),
    .stb_i    (stb_i),
    .ovf_clr_i(ovf_clr_i),
    .busy_o   (busy_o),
    .ovf_o    (ovf_o),
    .stb_o    (stb_o)
  );

  initial begin
    stb_i_clk = 1'b0;
    forever #(src_half) stb_i_clk = ~stb_i_clk;
  end

  // Destination clock can be parked low to let source counters fill up.
  initial begin
    stb_o_clk = 1'b0;
    forever begin
      if (dst_run) begin
        #(dst_half) stb_o_clk = ~stb_o_clk;
      end else begin
        stb_o_clk = 1'b0;
        #1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int q_count(input int ch);
    int n;
    n = 0;
    foreach (exp_q[i]) if (exp_q[i].ch == ch) n++;
    return n;
  endfunction

  task automatic push(input int ch, input realtime deadline);
    exp_t e;
    e.ch       = ch;
    e.deadline = deadline;
    exp_q.push_back(e);
  endtask

  task automatic src_cycles(input int n);
    repeat (n) @(negedge stb_i_clk);
  endtask

  // Drive a mask for n source edges, then release.
  task automatic hold(input logic [CH-1:0] mask, input int n);
    stb_i = mask;
    src_cycles(n);
    stb_i = '0;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge stb_i_clk);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy_o != '0 && k < budget) begin
      @(negedge stb_i_clk);
      k++;
    end
    check(name, 32'(busy_o), 32'd0);
  endtask

  // Monitor: every stb_o pulse must match an outstanding expected strobe.
  always @(negedge stb_o_clk) begin
    for (int c = 0; c < int'(CH); c++) begin
      if (stb_o[c] === 1'b1) begin
        pulse_cnt[c]++;
        if (stb_prev[c] === 1'b1) begin
          check($sformatf("stb_width_ch%0d", c), 32'd2, 32'd1);
        end else begin
          int idx;
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].ch == c) idx = i;
          end
          if (idx < 0) begin
            check($sformatf("unexpected_stb_ch%0d", c), 32'd1, 32'd0);
          end else begin
            if (exp_q[idx].deadline != 0.0 && $realtime > exp_q[idx].deadline)
              check($sformatf("late_stb_ch%0d", c), 32'($rtoi($realtime)),
                    32'($rtoi(exp_q[idx].deadline)));
            else
              check($sformatf("stb_ch%0d", c), 32'(c), 32'(exp_q[idx].ch));
            exp_q.delete(idx);
          end
        end
      end
    end
    stb_prev = stb_o;
  end

  initial begin
    int            base[CH];
    int            issued[CH];
    int            total;
    int            guard;
    logic [CH-1:0] m;

    n_vec     = 0;
    n_miss    = 0;
    stb_prev  = '0;
    for (int c = 0; c < int'(CH); c++) pulse_cnt[c] = 0;
    src_half  = 5.0;
    dst_half  = 15.0;
    dst_run   = 1'b1;
    lock_rst  = 1'b1;
    stb_i     = '0;
    ovf_clr_i = '0;

    // Reset state
    src_cycles(5);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ovf",  32'(ovf_o),  32'd0);
    check("rst_stb",  32'(stb_o),  32'd0);
    lock_rst = 1'b0;
    src_cycles(10);

    // 1: single strobe, 100 MHz -> 33 MHz, bounded latency
    base[0] = pulse_cnt[0];
    push(0, $realtime + 170.0);
    hold(4'b0001, 1);
    check("t1_busy_set", 32'(busy_o[0]), 32'd1);
    guard = 0;
    while (pulse_cnt[0] == base[0] && guard < 100) begin
      @(negedge stb_i_clk);
      guard++;
    end
    check("t1_pulse", 32'(pulse_cnt[0] - base[0]), 32'd1);
    check("t1_busy_during", 32'(busy_o[0]), 32'd1);
    wait_idle("t1_busy_clear", 100);
    src_cycles(20);
    check("t1_one_pulse", 32'(pulse_cnt[0] - base[0]), 32'd1);
    check("t1_drain", 32'(exp_q.size()), 32'd0);

    // 2: five back-to-back strobes, 200 MHz -> 25 MHz
    src_half = 2.5;
    dst_half = 20.0;
    src_cycles(4);
    base[1] = pulse_cnt[1];
    for (int i = 0; i < 5; i++) push(1, 0.0);
    hold(4'b0010, 5);
    drain("t2_drain", 4000);
    check("t2_count", 32'(pulse_cnt[1] - base[1]), 32'd5);
    check("t2_ovf", 32'(ovf_o[1]), 32'd0);
    wait_idle("t2_idle", 400);

    // 3: destination clock stopped, 20 strobes saturate at 15 and overflow
    src_half = 5.0;
    dst_half = 15.0;
    src_cycles(4);
    dst_run = 1'b0;
    src_cycles(4);
    base[2] = pulse_cnt[2];
    for (int i = 0; i < 15; i++) push(2, 0.0);
    hold(4'b0100, 20);
    check("t3_ovf_set", 32'(ovf_o[2]), 32'd1);
    check("t3_busy", 32'(busy_o[2]), 32'd1);
    dst_run = 1'b1;
    drain("t3_drain", 3000);
    src_cycles(40);
    check("t3_count", 32'(pulse_cnt[2] - base[2]), 32'd15);
    check("t3_ovf_sticky", 32'(ovf_o[2]), 32'd1);
    ovf_clr_i = 4'b0100;
    src_cycles(1);
    ovf_clr_i = '0;
    check("t3_ovf_clr", 32'(ovf_o[2]), 32'd0);
    wait_idle("t3_idle", 400);

    // 4: clear coincident with a dropped strobe leaves overflow set
    dst_run = 1'b0;
    src_cycles(4);
    base[2] = pulse_cnt[2];
    for (int i = 0; i < 15; i++) push(2, 0.0);
    hold(4'b0100, 15);
    check("t4_ovf_full_no_drop", 32'(ovf_o[2]), 32'd0);
    stb_i     = 4'b0100;
    ovf_clr_i = 4'b0100;
    src_cycles(1);
    stb_i     = '0;
    ovf_clr_i = '0;
    check("t4_ovf_set_wins", 32'(ovf_o[2]), 32'd1);
    ovf_clr_i = 4'b0100;
    src_cycles(1);
    ovf_clr_i = '0;
    check("t4_ovf_clr", 32'(ovf_o[2]), 32'd0);
    dst_run = 1'b1;
    drain("t4_drain", 3000);
    src_cycles(40);
    check("t4_count", 32'(pulse_cnt[2] - base[2]), 32'd15);
    wait_idle("t4_idle", 400);

    // 5: continuous strobes overlap decrements; then 1000 random strobes
    dst_half = 3.5;
    src_cycles(4);
    base[3] = pulse_cnt[3];
    for (int i = 0; i < 12; i++) push(3, 0.0);
    hold(4'b1000, 12);
    drain("t5_drain_hold", 2000);
    check("t5_count_hold", 32'(pulse_cnt[3] - base[3]), 32'd12);
    check("t5_ovf_hold", 32'(ovf_o[3]), 32'd0);
    for (int c = 0; c < int'(CH); c++) begin
      base[c]   = pulse_cnt[c];
      issued[c] = 0;
    end
    total = 0;
    guard = 0;
    while (total < 1000 && guard < 30000) begin
      m = '0;
      for (int c = 0; c < int'(CH); c++) begin
        if (total < 1000 && $urandom_range(0, 7) == 0 && q_count(c) < 12) begin
          m[c] = 1'b1;
          push(c, 0.0);
          issued[c]++;
          total++;
        end
      end
      stb_i = m;
      @(negedge stb_i_clk);
      guard++;
    end
    stb_i = '0;
    check("t5_issued", 32'(total), 32'd1000);
    drain("t5_drain_rand", 4000);
    src_cycles(40);
    for (int c = 0; c < int'(CH); c++)
      check($sformatf("t5_count_ch%0d", c), 32'(pulse_cnt[c] - base[c]), 32'(issued[c]));
    check("t5_ovf", 32'(ovf_o), 32'd0);
    wait_idle("t5_idle", 400);

    // 6: reset mid-handshake discards everything and emits no pulse
    dst_half = 15.0;
    src_cycles(4);
    dst_run = 1'b0;
    src_cycles(4);
    hold(4'b0001, 3);
    hold(4'b0100, 16);
    check("t6_busy_pre", 32'(busy_o), 32'h5);
    check("t6_ovf_pre", 32'(ovf_o), 32'h4);
    for (int c = 0; c < int'(CH); c++) base[c] = pulse_cnt[c];
    lock_rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_ovf",  32'(ovf_o),  32'd0);
    check("t6_rst_stb",  32'(stb_o),  32'd0);
    src_cycles(3);
    dst_run  = 1'b1;
    lock_rst = 1'b0;
    repeat (20) @(negedge stb_o_clk);
    check("t6_no_pulse", 32'((pulse_cnt[0] - base[0]) + (pulse_cnt[2] - base[2])), 32'd0);
    check("t6_busy_post", 32'(busy_o), 32'd0);
    @(negedge stb_i_clk);
    push(0, 0.0);
    hold(4'b0001, 1);
    drain("t6_drain", 400);
    repeat (20) @(negedge stb_o_clk);
    check("t6_one_pulse", 32'(pulse_cnt[0] - base[0]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
